// File: rtl/word_compare_ctrl.sv
// Multi-nibble word equality controller: compares two latched operands
// one nibble per clock (MSB nibble first) through a shared 4-bit
// equality comparator, with optional early exit on the first mismatch.
// Ports: clk, rst (sync, active-high), start, a, b in;
//        busy, done, eq, mism_idx out (all registered).

module nibble_eq (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic       eq
);
  assign eq = (x == y);
endmodule

module word_compare_ctrl #(
  parameter int NIBBLES    = 4,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int IDX_W     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic                   eq,
  output logic [IDX_W-1:0]       mism_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  logic [NIBBLES-1:0][3:0]   a_reg;
  logic [NIBBLES-1:0][3:0]   b_reg;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          mism_pending;
  logic                      flag;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic       nib_eq;
  logic       mis;
  logic       fin;

  assign nib_a = a_reg[idx];
  assign nib_b = b_reg[idx];

  nibble_eq u_cmp (
    .x  (nib_a),
    .y  (nib_b),
    .eq (nib_eq)
  );

  assign mis = ~nib_eq;
  // Last CMP cycle: either the bottom nibble or an early-exit mismatch.
  assign fin = (idx == '0) || (EARLY_EXIT && mis);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      eq           <= 1'b0;
      mism_idx     <= '0;
      idx          <= '0;
      mism_pending <= '0;
      flag         <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= IDX_W'(NIBBLES - 1);
            flag  <= 1'b0;
            busy  <= 1'b1;
            state <= CMP;
          end else begin
            state <= IDLE;
          end
        end
        CMP: begin
          if (mis && !flag) begin
            mism_pending <= idx;
            flag         <= 1'b1;
          end
          if (fin) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
            // Fold in a mismatch found on this final nibble.
            eq    <= ~(flag | mis);
            if (flag)
              mism_idx <= mism_pending;
            else if (mis)
              mism_idx <= idx;
            else
              mism_idx <= '0;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_compare_ctrl.sv
// Self-checking bench for word_compare_ctrl: one instance with early
// exit and one without, driven with identical stimulus.

module tb_word_compare_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;

  logic         busy1, done1, eq1;
  logic [1:0]   mi1;
  logic         busy0, done0, eq0;
  logic [1:0]   mi0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  word_compare_ctrl #(.NIBBLES(N), .EARLY_EXIT(1'b1)) u_ee1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a_in),
    .b        (b_in),
    .busy     (busy1),
    .done     (done1),
    .eq       (eq1),
    .mism_idx (mi1)
  );

  word_compare_ctrl #(.NIBBLES(N), .EARLY_EXIT(1'b0)) u_ee0 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a_in),
    .b        (b_in),
    .busy     (busy0),
    .done     (done0),
    .eq       (eq0),
    .mism_idx (mi0)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: highest-index differing nibble, or -1 when equal.
  function automatic int first_mism(input logic [W-1:0] x,
                                    input logic [W-1:0] y);
    logic [3:0] nx, ny;
    for (int k = N - 1; k >= 0; k--) begin
      nx = x[4*k +: 4];
      ny = y[4*k +: 4];
      if (nx != ny) return k;
    end
    return -1;
  endfunction

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy1"}, int'(busy1), 0);
    check({tag, "_done1"}, int'(done1), 0);
    check({tag, "_eq1"},   int'(eq1),   0);
    check({tag, "_mi1"},   int'(mi1),   0);
    check({tag, "_busy0"}, int'(busy0), 0);
    check({tag, "_done0"}, int'(done0), 0);
    check({tag, "_eq0"},   int'(eq0),   0);
    check({tag, "_mi0"},   int'(mi0),   0);
  endtask

  // Observe one operation accepted at the edge before the next negedge.
  // mode 0: drop start at cycle 1; 1: hold start (back-to-back);
  // 2: pulse start with garbage operands while busy.
  task automatic watch(input string tag, input logic [W-1:0] ea,
                       input logic [W-1:0] eb, input int mode,
                       input logic [W-1:0] na, input logic [W-1:0] nb);
    int k, lat1, lat0, dc1, dc0, nd1, nd0, last;
    k    = first_mism(ea, eb);
    lat0 = N + 1;
    lat1 = (k >= 0) ? (N - k + 1) : (N + 1);
    last = (mode == 1) ? N + 1 : N + 3;
    dc1 = 0; dc0 = 0; nd1 = 0; nd0 = 0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      check({tag, "_busy1"}, int'(busy1), (c < lat1) ? 1 : 0);
      check({tag, "_busy0"}, int'(busy0), (c < lat0) ? 1 : 0);
      if (done1) begin nd1++; dc1 = c; end
      if (done0) begin nd0++; dc0 = c; end
      if (mode == 0 && c == 1) start = 1'b0;
      if (mode == 1 && c == 1) begin a_in = na; b_in = nb; end
      if (mode == 2 && c == 1) start = 1'b0;
      if (mode == 2 && c == 2) begin
        start = 1'b1;
        a_in  = W'($urandom);
        b_in  = ~a_in;
      end
      if (mode == 2 && c == N - 1) start = 1'b0;
    end
    check({tag, "_ndone1"}, nd1, 1);
    check({tag, "_ndone0"}, nd0, 1);
    check({tag, "_lat1"},   dc1, lat1);
    check({tag, "_lat0"},   dc0, lat0);
    check({tag, "_eq1"},    int'(eq1), (k < 0) ? 1 : 0);
    check({tag, "_eq0"},    int'(eq0), (k < 0) ? 1 : 0);
    check({tag, "_mi1"},    int'(mi1), (k < 0) ? 0 : k);
    check({tag, "_mi0"},    int'(mi0), (k < 0) ? 0 : k);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x,
                        input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    a_in  = x;
    b_in  = y;
    watch(tag, x, y, 0, '0, '0);
  endtask

  always @(negedge clk) begin
    if (busy1 && done1) $display("FAIL overlap1: busy and done both 1");
    if (busy0 && done0) $display("FAIL overlap0: busy and done both 1");
  end

  initial begin
    logic [W-1:0] x, y, x2, y2;
    int nd;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_reset_outs("idle");
    end

    run_op("match",  16'hA5C3, 16'hA5C3);
    run_op("early",  16'h1234, 16'h1F34);
    run_op("multi",  16'h1234, 16'h0F30);
    run_op("low",    16'h1234, 16'h1235);

    // Operands change and start pulses mid-run; original result stands.
    @(negedge clk);
    start = 1'b1;
    a_in  = 16'hFFFF;
    b_in  = 16'hFFFF;
    watch("busy_start", 16'hFFFF, 16'hFFFF, 2, '0, '0);

    // Back-to-back: second op accepted in the DONE cycle of the first.
    x2 = 16'h9ABC;
    y2 = 16'h9AB0;
    @(negedge clk);
    start = 1'b1;
    a_in  = 16'h4321;
    b_in  = 16'h4321;
    watch("b2b_1", 16'h4321, 16'h4321, 1, x2, y2);
    watch("b2b_2", x2, y2, 0, '0, '0);

    // Reset during the second CMP cycle.
    @(negedge clk);
    start = 1'b1;
    a_in  = 16'h5555;
    b_in  = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outs("midrst");
    nd = 0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      if (done1 || done0) nd++;
    end
    check("midrst_nodone", nd, 0);
    run_op("after_rst", 16'h0F0F, 16'h0F0F);

    for (int i = 0; i < 40; i++) begin
      x = W'($urandom);
      y = x;
      if ($urandom_range(0, 2) != 0)
        y[4*$urandom_range(0, N-1) +: 4] ^= 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0)
        y[4*$urandom_range(0, N-1) +: 4] ^= 4'($urandom_range(1, 15));
      run_op($sformatf("rnd%0d", i), x, y);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
